// File: rtl/sample_frame_pkg.sv
// Shared definitions for the sampler dump-stream record: delimiter,
// payload length, deframer state encoding and the 7-bit checksum.
package sample_frame_pkg;

  localparam logic [7:0] FRAME_DELIM         = 8'h0A;
  localparam int         FRAME_PAYLOAD_BYTES = 5;

  // Deframer states: hunting for the delimiter, five payload bytes, checksum compare
  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    B1    = 3'd1,
    B2    = 3'd2,
    B3    = 3'd3,
    B4    = 3'd4,
    B5    = 3'd5,
    CHECK = 3'd6
  } frame_state_t;

  // Three 8-bit operands summed at 10 bits, truncated to 7 bits
  function automatic logic [6:0] frame_checksum(input logic [11:0] v,
                                                input logic [11:0] i);
    logic [9:0] s;
    s = {2'b00, v[11:4]} + {2'b00, v[3:0], i[11:8]} + {2'b00, i[7:0]};
    return s[6:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit confirm at half
// bit, centre sampling LSB first. Emits byte_strobe for a good stop bit or
// stop_err for a low stop bit (then waits for the line to return high).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       stop_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

  rx_state_t     st;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  // Bring the asynchronous pin into the clk domain; idle level is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx_pin};
  end

  // Bit-timing FSM; strobes are single-cycle and registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= R_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_strobe <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      stop_err    <= 1'b0;
      case (st)
        R_IDLE: begin
          cnt <= '0;
          if (!rx_s) st <= R_START;
        end
        R_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_s ? R_IDLE : R_DATA;  // glitch: back to idle
          end else cnt <= cnt + 1'b1;
        end
        R_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) st <= R_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        R_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx_s) begin
              byte_strobe <= 1'b1;
              st          <= R_IDLE;
            end else begin
              stop_err <= 1'b1;
              st       <= R_BREAK;
            end
          end else cnt <= cnt + 1'b1;
        end
        // A low stop bit must not be mistaken for the next start bit
        R_BREAK: if (rx_s) st <= R_IDLE;
        default: st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sample_frame_rx.sv
// Sampler dump-stream decoder: deframes 0x0A + 5 payload bytes, rebuilds
// the 32-bit sample word and checks the 7-bit checksum.
// Optional: SAMPLE_FRAME_RX_CHECKSUM_EN enables the checksum compare;
// without it every structurally valid frame is accepted and chk_err stays 0.
module sample_frame_rx
  import sample_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_pin,
  output logic        frame_valid,
  output logic [31:0] frame_word,
  output logic [11:0] data_v,
  output logic [11:0] data_i,
  output logic        chk_err,
  output logic        frame_err,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int            TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW       = $clog2(TO_LIMIT);
  localparam logic [TW-1:0] TO_TERM  = TW'(TO_LIMIT - 1);

  logic          byte_strobe, stop_err;
  logic [7:0]    rx_byte;
  frame_state_t  state;
  logic [11:0]   cap_v, cap_i;
  logic [6:0]    cap_chk;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_pin      (uart_rx_pin),
    .byte_strobe (byte_strobe),
    .rx_byte     (rx_byte),
    .stop_err    (stop_err)
  );

  assign busy   = state inside {B1, B2, B3, B4, B5};
  assign to_hit = (to_cnt == TO_TERM);
  assign data_v = frame_word[31:20];
  assign data_i = frame_word[19:8];

  // Inter-byte gap counter: runs only mid-frame, restarts on every strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  to_cnt <= '0;
    else if (!busy || byte_strobe || stop_err) to_cnt <= '0;
    else if (!to_hit)                          to_cnt <= to_cnt + 1'b1;
  end

  // Deframer FSM with registered pulses and held output word/count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      cap_v       <= '0;
      cap_i       <= '0;
      cap_chk     <= '0;
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      frame_err   <= 1'b0;
      frame_word  <= '0;
      frame_count <= '0;
    end else begin
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      frame_err   <= 1'b0;
      if (busy && (stop_err || (to_hit && !byte_strobe))) begin
        frame_err <= 1'b1;
        state     <= HUNT;
      end else begin
        case (state)
          HUNT: if (byte_strobe && rx_byte == FRAME_DELIM) state <= B1;
          B1: if (byte_strobe) begin
            if (rx_byte[7:4] != 4'h0) begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end else begin
              cap_v[11:8] <= rx_byte[3:0];
              state       <= B2;
            end
          end
          B2: if (byte_strobe) begin
            cap_v[7:0] <= rx_byte;
            state      <= B3;
          end
          B3: if (byte_strobe) begin
            if (rx_byte[7:4] != 4'h0) begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end else begin
              cap_i[11:8] <= rx_byte[3:0];
              state       <= B4;
            end
          end
          B4: if (byte_strobe) begin
            cap_i[7:0] <= rx_byte;
            state      <= B5;
          end
          B5: if (byte_strobe) begin
            if (rx_byte[7]) begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end else begin
              cap_chk <= rx_byte[6:0];
              state   <= CHECK;
            end
          end
          CHECK: begin
`ifdef SAMPLE_FRAME_RX_CHECKSUM_EN
            if (frame_checksum(cap_v, cap_i) == cap_chk) begin
              frame_valid <= 1'b1;
              frame_word  <= {cap_v, cap_i, cap_chk, 1'b1};
              frame_count <= frame_count + 16'd1;
            end else begin
              chk_err <= 1'b1;
            end
`else
            frame_valid <= 1'b1;
            frame_word  <= {cap_v, cap_i, cap_chk, 1'b1};
            frame_count <= frame_count + 16'd1;
`endif
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_rx.sv
// Scoreboard bench for sample_frame_rx: expected pulses are queued as
// stimulus is sent and matched against DUT pulses on the falling edge.
module tb_sample_frame_rx;
  import sample_frame_pkg::*;

  localparam int CPB = 16;
  localparam int TOB = 20;
  localparam int K_VALID = 1, K_CHK = 2, K_FERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pin = 1'b1;
  logic        frame_valid, chk_err, frame_err, busy;
  logic [31:0] frame_word;
  logic [11:0] data_v, data_i;
  logic [15:0] frame_count;

  typedef struct {
    int          kind;
    logic [31:0] word;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_word = '0;
  logic [15:0] m_cnt  = '0;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sample_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_pin (pin),
    .frame_valid (frame_valid),
    .frame_word  (frame_word),
    .data_v      (data_v),
    .data_i      (data_i),
    .chk_err     (chk_err),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue the expected pulse and advance the output model
  task automatic push_exp(input int kind, input logic [11:0] v, input logic [11:0] i,
                          input logic [6:0] c);
    exp_t e;
    if (kind == K_VALID) begin
      m_word = {v, i, c, 1'b1};
      m_cnt  = m_cnt + 16'd1;
    end
    e.kind = kind;
    e.word = m_word;
    e.cnt  = m_cnt;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    pin = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      pin = b[k];
      repeat (CPB) @(posedge clk);
    end
    pin = stop;
    repeat (CPB) @(posedge clk);
    pin = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic send_frame(input string tag, input logic [11:0] v, input logic [11:0] i,
                            input logic [7:0] b5, input int kind);
    push_exp(kind, v, i, b5[6:0]);
    send_byte(FRAME_DELIM);
    send_byte({4'h0, v[11:8]});
    send_byte(v[7:0]);
    send_byte({4'h0, i[11:8]});
    send_byte(i[7:0]);
    send_byte(b5);
    drain(tag, 4);
  endtask

  // Output monitor: every pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst && (frame_valid || chk_err || frame_err)) begin
      int   obs;
      exp_t e;
      obs = frame_valid ? K_VALID : (chk_err ? K_CHK : K_FERR);
      check("pulse_excl", int'(frame_valid) + int'(chk_err) + int'(frame_err), 1);
      if (q.size() == 0) begin
        check("unexpected_pulse", obs, 0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", obs, e.kind);
        check("word", frame_word, e.word);
        check("data_v", data_v, e.word[31:20]);
        check("data_i", data_i, e.word[19:8]);
        check("count", frame_count, e.cnt);
      end
    end
  end

  initial begin
    logic [11:0] rv, ri;
    int          bad_kind;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_word", frame_word, 0);
    check("rst_count", frame_count, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_valid, chk_err, frame_err}, 0);
    rst = 1'b1;
    repeat (2 * CPB) @(posedge clk);

    // Junk in HUNT is ignored silently
    send_byte(8'h55);
    send_byte(8'hA0);
    check("hunt_busy", busy, 0);

    // Clean frame v=ABC i=123 chk=0F
    send_frame("clean", 12'hABC, 12'h123, 8'h0F, K_VALID);
    check("clean_word", frame_word, 32'hABC1231F);
    check("clean_v", data_v, 12'hABC);
    check("clean_i", data_i, 12'h123);
    check("clean_cnt", frame_count, 1);

    // Wrong checksum
`ifdef SAMPLE_FRAME_RX_CHECKSUM_EN
    bad_kind = K_CHK;
`else
    bad_kind = K_VALID;
`endif
    send_frame("badchk", 12'hABC, 12'h123, 8'h10, bad_kind);
`ifdef SAMPLE_FRAME_RX_CHECKSUM_EN
    check("badchk_word", frame_word, 32'hABC1231F);
    check("badchk_cnt", frame_count, 1);
`else
    check("badchk_word", frame_word, 32'hABC12321);
    check("badchk_cnt", frame_count, 2);
`endif

    // B1 upper nibble set
    send_byte(FRAME_DELIM);
    push_exp(K_FERR, 12'h0, 12'h0, 7'h0);
    send_byte(8'h1A);
    drain("b1_nibble", 4);
    check("b1_busy", busy, 0);

    // Back-to-back valid frames, checksum from the package function
    for (int n = 0; n < 3; n++) begin
      rv = 12'($urandom);
      ri = 12'($urandom);
      send_frame("b2b", rv, ri, {1'b0, frame_checksum(rv, ri)}, K_VALID);
    end

    // B3 upper nibble set
    send_byte(FRAME_DELIM); send_byte(8'h0A); send_byte(8'hBC);
    push_exp(K_FERR, 12'h0, 12'h0, 7'h0);
    send_byte(8'h13);
    drain("b3_nibble", 4);

    // B5 bit7 set
    send_byte(FRAME_DELIM); send_byte(8'h0A); send_byte(8'hBC);
    send_byte(8'h01); send_byte(8'h23);
    push_exp(K_FERR, 12'h0, 12'h0, 7'h0);
    send_byte(8'h8F);
    drain("b5_bit7", 4);

    // Inter-byte timeout mid-frame
    send_byte(FRAME_DELIM); send_byte(8'h0A);
    check("to_busy", busy, 1);
    push_exp(K_FERR, 12'h0, 12'h0, 7'h0);
    repeat (TOB * CPB - 40) @(posedge clk);
    check("to_early", q.size(), 1);
    drain("timeout", 100);
    check("to_idle_busy", busy, 0);

    // Stop bit low during B3
    send_byte(FRAME_DELIM); send_byte(8'h0A); send_byte(8'hBC);
    push_exp(K_FERR, 12'h0, 12'h0, 7'h0);
    send_byte(8'h01, 1'b0);
    drain("stop_err", 4);
    repeat (2 * CPB) @(posedge clk);
    send_frame("recover", 12'h5F3, 12'h0C7, {1'b0, frame_checksum(12'h5F3, 12'h0C7)}, K_VALID);

    // Reset mid-frame drops everything
    send_byte(FRAME_DELIM); send_byte(8'h0A); send_byte(8'hBC);
    check("mid_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_word", frame_word, 0);
    check("mrst_v", data_v, 0);
    check("mrst_i", data_i, 0);
    check("mrst_count", frame_count, 0);
    check("mrst_busy", busy, 0);
    m_word = '0;
    m_cnt  = '0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    send_frame("post_rst", 12'hABC, 12'h123, 8'h0F, K_VALID);
    check("post_rst_cnt", frame_count, 1);

    repeat (CPB) @(posedge clk);
    check("q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
